fetch_queue: RTL and testbench

Instruction prefetch stage for the pipelined float processor. It sits between instruction memory and the decode/register-read stages. It issues sequential 16-bit fetches over a req/ack memory port and buffers `{pc, ir}` pairs in a small FIFO. Buffered entries are presented to decode on a valid/ready handshake. A taken `jz` redirects the queue: queued entries are flushed and any in-flight fetch is discarded.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 62 ++++++
 rtl/fetch_queue.sv | 109 ++++++++++
 tb/tb_fetch_queue.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package fetch_pkg;

    localparam int WORD_W   = 16;
    localparam int FQ_DEPTH = 4;

    localparam logic [WORD_W-1:0] RESET_PC = 16'h0000;

    // One buffered fetch: the address it came from and the word returned.
    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] ir;
    } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of {pc, ir} entries with head/tail pointers and an
// occupancy count. Flush empties the buffer and wins over push/pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = FQ_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fq_entry_t        wdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output fq_entry_t        head_entry
);

    fq_entry_t        slots [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    // Pointer, count and storage update; DEPTH is a power of two so the
    // pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            // NOTE: storage is reset because the head entry drives the
            // outputs directly and must read zero straight out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                slots[tail] <= wdata;
                tail        <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign head_entry = slots[head];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch stage: issues sequential fetches over a req/ack
// memory port, buffers {pc, ir} pairs and presents them to decode. A taken
// jz (redirect) flushes the queue and discards any in-flight fetch.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             halt,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_ir,
    output logic [WIDTH-1:0] out_pc,
    input  logic             out_ready
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] fetch_pc;
    logic [WIDTH-1:0] fetch_pc_next;
    logic             discard;
    logic             transfer;
    logic             hold;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] cnt_next;
    logic             req_next;
    fq_entry_t        wdata;
    fq_entry_t        head_entry;

    assign transfer = mem_req && mem_ack;
    // A request still waiting for its ack keeps mem_req/mem_addr frozen.
    assign hold     = mem_req && !mem_ack;
    // Redirect beats both push and pop; acked data during a discard is dropped.
    assign push     = transfer && !discard && !redirect && !full;
    assign pop      = out_valid && out_ready && !redirect;
    assign wdata    = '{pc: mem_addr, ir: mem_data};

    assign fetch_pc_next = redirect ? redirect_pc
                         : push     ? fetch_pc + 1'b1
                         :            fetch_pc;

    // Post-edge occupancy, used to reserve room before starting a request.
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        cnt_next = fifo_count;
        if (redirect) begin
            cnt_next = '0;
        end else if (push && !pop) begin
            cnt_next = fifo_count + 1'b1;
        end else if (pop && !push) begin
            cnt_next = fifo_count - 1'b1;
        end
    end

    assign req_next = !halt && (cnt_next < CNT_W'(DEPTH));

    // Fetch PC, discard flag and the registered memory request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            discard  <= 1'b0;
            mem_req  <= 1'b0;
            mem_addr <= RESET_PC;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            fetch_pc <= fetch_pc_next;
            if (redirect && hold) begin
                discard <= 1'b1;
            end else if (transfer) begin
                discard <= 1'b0;
            end
            if (!hold) begin
                mem_req  <= req_next;
                mem_addr <= fetch_pc_next;
            end
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .flush      (redirect),
        .wdata      (wdata),
        .full       (full),
        .empty      (empty),
        .count      (fifo_count),
        .head_entry (head_entry)
    );

    assign out_valid = !empty;
    assign out_ir    = head_entry.ir;
    assign out_pc    = head_entry.pc;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a variable-latency memory model.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        halt;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_data;
    logic        out_valid;
    logic [15:0] out_ir;
    logic [15:0] out_pc;
    logic        out_ready;

    int checks = 0;
    int errors = 0;
    int lat    = 0;
    int wcnt;
    int xfers  = 0;
    int pop5   = 0;
    logic [15:0] tmp;

    always #5 clk = ~clk;

    fetch_queue dut (
        .clk         (clk),
        .reset       (reset),
        .halt        (halt),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data),
        .out_valid   (out_valid),
        .out_ir      (out_ir),
        .out_pc      (out_pc),
        .out_ready   (out_ready)
    );

    // Memory: acks once a request has waited lat cycles; word = addr ^ A5A5.
    always @(posedge clk or negedge reset) begin
        if (!reset) wcnt <= 0;
        else if (!mem_req || mem_ack) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end
    assign mem_ack  = mem_req && (wcnt >= lat);
    assign mem_data = mem_addr ^ 16'hA5A5;

    // Event counters: completed transfers and pops of address 5.
    always @(posedge clk) begin
        if (reset && mem_req && mem_ack) xfers++;
        if (reset && out_valid && out_ready && !redirect && out_pc == 16'h0005) pop5++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int l, input logic rdy);
        @(negedge clk);
        reset = 1'b0; lat = l; out_ready = rdy; halt = 1'b0; redirect = 1'b0;
        @(negedge clk);
        xfers = 0; pop5 = 0;
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench timed out");
    end

    initial begin
        reset = 1'b0; halt = 1'b0; redirect = 1'b0; redirect_pc = '0;
        out_ready = 1'b1; lat = 0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_ir", out_ir, 0);
        chk("rst_out_pc", out_pc, 0);

        // Reset release with zero-wait memory
        reset = 1'b1;
        @(negedge clk);
        chk("rel_req", mem_req, 1);
        chk("rel_addr", mem_addr, 0);
        chk("rel_valid0", out_valid, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rel_valid", out_valid, 1);
            chk("rel_pc", out_pc, i);
            chk("rel_ir", out_ir, i ^ 32'h0000A5A5);
        end

        // Backpressure: four entries fill the queue, then requests stop
        do_reset(0, 1'b0);
        repeat (10) @(negedge clk);
        chk("bp_xfers", xfers, 4);
        chk("bp_req", mem_req, 0);
        chk("bp_valid", out_valid, 1);
        chk("bp_pc0", out_pc, 0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_pc1", out_pc, 1);
        chk("bp_resume_req", mem_req, 1);
        chk("bp_resume_addr", mem_addr, 4);
        @(negedge clk);
        chk("bp_pc2", out_pc, 2);
        @(negedge clk);
        chk("bp_pc3", out_pc, 3);
        @(negedge clk);
        chk("bp_pc4", out_pc, 4);
        chk("bp_ir4", out_ir, 32'h0000A5A1);

        // Redirect while fetch of address 5 is outstanding (3-cycle ack)
        do_reset(2, 1'b1);
        for (int i = 0; i < 200 && !(mem_req && mem_addr == 16'h0005); i++) @(negedge clk);
        chk("rd_reach5", (mem_req && mem_addr == 16'h0005), 1);
        redirect = 1'b1; redirect_pc = 16'h0100;
        @(negedge clk);
        redirect = 1'b0;
        chk("rd_valid", out_valid, 0);
        chk("rd_hold_req", mem_req, 1);
        chk("rd_hold_addr", mem_addr, 5);
        for (int i = 0; i < 20 && mem_addr == 16'h0005; i++) @(negedge clk);
        chk("rd_next_req", mem_req, 1);
        chk("rd_next_addr", mem_addr, 16'h0100);
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        chk("rd_out_valid", out_valid, 1);
        chk("rd_out_pc", out_pc, 16'h0100);
        chk("rd_out_ir", out_ir, 16'h0100 ^ 16'hA5A5);
        chk("rd_pop5", pop5, 0);

        // Redirect coinciding with an ack and a pop (zero-wait memory)
        lat = 0;
        repeat (3) @(negedge clk);
        chk("co_pre_valid", out_valid, 1);
        chk("co_pre_ack", mem_ack, 1);
        tmp = mem_addr;
        redirect = 1'b1; redirect_pc = 16'h0200;
        @(negedge clk);
        redirect = 1'b0;
        chk("co_valid", out_valid, 0);
        chk("co_req", mem_req, 1);
        chk("co_addr", mem_addr, 16'h0200);
        @(negedge clk);
        chk("co_out_valid", out_valid, 1);
        chk("co_out_pc", out_pc, 16'h0200);
        chk("co_dropped", (out_pc == tmp), 0);

        // PC wrap from FFFE
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        @(negedge clk);
        redirect = 1'b0;
        chk("wr_valid", out_valid, 0);
        @(negedge clk);
        chk("wr_pc_fffe", out_pc, 16'hFFFE);
        chk("wr_ir_fffe", out_ir, 16'h5A5B);
        @(negedge clk);
        chk("wr_pc_ffff", out_pc, 16'hFFFF);
        chk("wr_ir_ffff", out_ir, 16'h5A5A);
        @(negedge clk);
        chk("wr_pc_0000", out_pc, 16'h0000);
        chk("wr_ir_0000", out_ir, 16'hA5A5);

        // Halt while address 7 is pending
        do_reset(2, 1'b1);
        for (int i = 0; i < 200 && !(mem_req && mem_addr == 16'h0007); i++) @(negedge clk);
        chk("ht_reach7", (mem_req && mem_addr == 16'h0007), 1);
        halt = 1'b1;
        xfers = 0;
        @(negedge clk);
        chk("ht_pend_req", mem_req, 1);
        chk("ht_pend_addr", mem_addr, 7);
        for (int i = 0; i < 20 && !(out_valid && out_pc == 16'h0007); i++) @(negedge clk);
        chk("ht_pc7", out_pc, 7);
        chk("ht_ir7", out_ir, 16'h0007 ^ 16'hA5A5);
        repeat (4) @(negedge clk);
        chk("ht_no_req", mem_req, 0);
        chk("ht_xfers", xfers, 1);
        chk("ht_empty", out_valid, 0);
        halt = 1'b0;
        @(negedge clk);
        chk("ht_resume_req", mem_req, 1);
        chk("ht_resume_addr", mem_addr, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
